// File: rtl/lcd_disp_interface.sv
// rtl/lcd_disp_interface.sv - HD44780 write-only byte transmitter with RS/E/DB timing
// Define LCD_4BIT_EN to send each byte as two nibbles on lcd_data[7:4].
module lcd_disp_interface #(
  parameter int T_AS     = 2,
  parameter int T_PW     = 4,
  parameter int T_H      = 2,
  parameter int EXEC_CYC = 8,
  parameter int LONG_CYC = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       ins_data,
  input  logic       send_data,
  output logic       busy,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int MAX_A = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int MAX_B = (T_H > EXEC_CYC) ? T_H : EXEC_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAXP  = (MAX_C > LONG_CYC) ? MAX_C : LONG_CYC;
  localparam int CW    = $clog2(MAXP + 1);

  generate
    if (T_AS < 1 || T_PW < 1 || T_H < 1 || EXEC_CYC < 1 || LONG_CYC < 1) begin : g_param_chk
      $error("lcd_disp_interface: all timing parameters must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          long_q;
`ifdef LCD_4BIT_EN
  logic [3:0]    lo_nib;
  logic          second;
`endif

  assign lcd_rw = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_data <= 8'h00;
`ifdef LCD_4BIT_EN
      lo_nib   <= 4'h0;
      second   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (send_data) begin
            state  <= S_SETUP;
            cnt    <= CW'(T_AS - 1);
            busy   <= 1'b1;
            lcd_rs <= ins_data;
            // Clear display and return home need the long execution wait
            long_q <= !ins_data && (data == 8'h01 || data == 8'h02 || data == 8'h03);
`ifdef LCD_4BIT_EN
            lcd_data <= {data[7:4], 4'h0};
            lo_nib   <= data[3:0];
            second   <= 1'b0;
`else
            lcd_data <= data;
`endif
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            state <= S_PULSE;
            lcd_e <= 1'b1;
            cnt   <= CW'(T_PW - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            state <= S_HOLD;
            lcd_e <= 1'b0;
            cnt   <= CW'(T_H - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
`ifdef LCD_4BIT_EN
            if (!second) begin
              state    <= S_SETUP;
              lcd_data <= {lo_nib, 4'h0};
              second   <= 1'b1;
              cnt      <= CW'(T_AS - 1);
            end else begin
`else
            begin
`endif
              state <= S_WAIT;
              cnt   <= long_q ? CW'(LONG_CYC - 1) : CW'(EXEC_CYC - 1);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          lcd_e <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_disp_interface.sv
// tb/tb_lcd_disp_interface.sv - scoreboard bench for lcd_disp_interface
// Build with LCD_4BIT_EN defined to exercise the 4-bit bus mode.
module tb_lcd_disp_interface;

  localparam int T_AS = 2, T_PW = 4, T_H = 2, EXEC = 8, LONG = 32;
`ifdef LCD_4BIT_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ins_data = 1'b0;
  logic       send_data = 1'b0;
  logic       busy, done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  lcd_disp_interface dut (
    .clk(clk), .rst(rst), .data(data), .ins_data(ins_data), .send_data(send_data),
    .busy(busy), .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] bus0;
    logic [7:0] bus1;
    logic [7:0] bus_last;
    int         npulse;
    int         busy_len;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected transfer derived from the command set: clear/home are slow, everything else is fast
  function automatic exp_t model(input logic [7:0] d, input logic ins);
    exp_t e;
    int   wait_c;
    wait_c     = (!ins && d >= 8'd1 && d <= 8'd3) ? LONG : EXEC;
    e.rs       = ins;
    e.npulse   = NP;
    e.busy_len = NP * (T_AS + T_PW + T_H) + wait_c;
`ifdef LCD_4BIT_EN
    e.bus0     = {d[7:4], 4'h0};
    e.bus1     = {d[3:0], 4'h0};
    e.bus_last = e.bus1;
`else
    e.bus0     = d;
    e.bus1     = d;
    e.bus_last = d;
`endif
    return e;
  endfunction

  int         bcnt = 0, pc = 0, e_run = 0, first_e = 0;
  int         width [2];
  logic [7:0] seen [2];
  logic       rs_seen [2];
  exp_t       me;

  always @(negedge clk) begin
    if (!rst) begin
      bcnt = 0; pc = 0; e_run = 0; first_e = 0;
    end else begin
      if (!busy) chk("e_low_when_idle", {31'd0, lcd_e}, 32'd0);
      if (busy) begin
        bcnt++;
        if (lcd_e) begin
          if (e_run == 0 && pc < 2) begin
            seen[pc]    = lcd_data;
            rs_seen[pc] = lcd_rs;
            if (pc == 0) first_e = bcnt;
          end
          e_run++;
        end else if (e_run > 0) begin
          if (pc < 2) width[pc] = e_run;
          pc++;
          e_run = 0;
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: actual done=1 required no transfer pending at %0t", $time);
        end else begin
          me = q.pop_front();
          chk("busy_low_on_done", {31'd0, busy}, 32'd0);
          chk("busy_cycles", bcnt, me.busy_len);
          chk("e_pulse_count", pc, me.npulse);
          chk("e_rise_after_setup", first_e, T_AS + 1);
          for (int i = 0; i < me.npulse && i < 2; i++) begin
            chk("e_pulse_width", width[i], T_PW);
            chk("rs_during_e", {31'd0, rs_seen[i]}, {31'd0, me.rs});
            chk("data_during_e", {24'd0, seen[i]}, {24'd0, (i == 0) ? me.bus0 : me.bus1});
          end
          chk("data_kept_after_done", {24'd0, lcd_data}, {24'd0, me.bus_last});
          chk("rs_kept_after_done", {31'd0, lcd_rs}, {31'd0, me.rs});
          chk("rw_low", {31'd0, lcd_rw}, 32'd0);
        end
        bcnt = 0; pc = 0; e_run = 0; first_e = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle_timeout: actual busy=%0d required 0", busy);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic ins, input bit junk);
    wait_idle();
    data = d; ins_data = ins; send_data = 1'b1;
    q.push_back(model(d, ins));
    @(negedge clk);
    send_data = 1'b0;
    data = 8'($urandom);
    ins_data = 1'($urandom);
    if (junk) begin
      repeat ($urandom_range(8, 12)) @(negedge clk);
      if (busy) begin
        send_data = 1'b1; data = 8'h55; ins_data = 1'b1;
        @(negedge clk);
        send_data = 1'b0;
      end
    end
  endtask

  task automatic hold_high(input logic [7:0] d, input logic ins, input int k);
    int n = 1;
    int guard = 0;
    wait_idle();
    data = d; ins_data = ins; send_data = 1'b1;
    q.push_back(model(d, ins));
    while (n < k && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (!busy) begin
        q.push_back(model(d, ins));
        n++;
      end
    end
    @(negedge clk);
    while (busy && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      n_chk++;
      n_fail++;
      $display("FAIL hold_high_timeout: actual accepts=%0d required %0d", n, k);
    end
    send_data = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       ins;
    int         n;

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_e", {31'd0, lcd_e}, 32'd0);
    chk("reset_rs", {31'd0, lcd_rs}, 32'd0);
    chk("reset_rw", {31'd0, lcd_rw}, 32'd0);
    chk("reset_data", {24'd0, lcd_data}, 32'd0);
    rst = 1'b1;

    send(8'h41, 1'b1, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    send(8'h38, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    send(8'h38, 1'b0, 1'b1);

    // Abort a transfer in the middle of its E pulse
    send(8'h41, 1'b1, 1'b0);
    n = 0;
    while (!lcd_e && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("e_seen_before_abort", {31'd0, lcd_e}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_e", {31'd0, lcd_e}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_data", {24'd0, lcd_data}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    q.delete();
    rst = 1'b1;
    repeat (3) @(negedge clk);

    hold_high(8'h41, 1'b1, 3);
    hold_high(8'h02, 1'b0, 2);

    repeat (40) begin
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 3));
      ins = 1'($urandom);
      send(d, ins, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_idle();
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
